// File: rtl/pipeline_pkg.sv
// Types and constants shared by the pipeline stage blocks:
// the packed stage payload, its NOP value and occupancy classification.
package pipeline_pkg;

    typedef struct packed {
        logic [15:0] pc;
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic        reg_wr;
        logic        mem_rd;
        logic        mem_wr;
        logic        branch;
    } pipeline_signal_packed_t;

    localparam int PIPE_W = $bits(pipeline_signal_packed_t);

    localparam pipeline_signal_packed_t PIPE_NOP = '0;

    typedef enum logic [1:0] {
        OCC_EMPTY   = 2'd0,
        OCC_PARTIAL = 2'd1,
        OCC_FULL    = 2'd2
    } occ_state_e;

    function automatic occ_state_e occ_state(input int unsigned cnt, input int unsigned depth);
        if (cnt == 0)
            return OCC_EMPTY;
        else if (cnt == depth)
            return OCC_FULL;
        else
            return OCC_PARTIAL;
    endfunction

endpackage

// File: rtl/pipeline_ptr_ctr.sv
// Wrapping W-bit pointer with increment and synchronous clear; clear wins.
// Wrap is the natural modulo-2^W overflow, so DEPTH must be a power of two.
module pipeline_ptr_ctr #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] ptr_o
);

    logic [W-1:0] ptr_q;
    logic [W-1:0] ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (clr_i)
            ptr_d = '0;
        else if (inc_i)
            ptr_d = ptr_q + W'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            ptr_q <= '0;
        else
            ptr_q <= ptr_d;
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/pipeline_stage_buffer.sv
// DEPTH-entry elastic buffer between two pipeline stages with valid/ready on both
// sides plus hazard-controller stall, bubble and nullify on the downstream side.
module pipeline_stage_buffer
    import pipeline_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    input  logic             stall,
    input  logic             bubble,
    input  logic             nullify,
    output logic [CW-1:0]    count,
    output logic [CW-1:0]    flushed
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [WIDTH-1:0] NOP_PAYLOAD = WIDTH'(PIPE_NOP);

    logic [WIDTH-1:0] storage_q [DEPTH];
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic [CW-1:0]    flushed_q;
    logic [CW-1:0]    flushed_d;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    occ_state_e       occ;
    logic             enq;
    logic             deq;

    assign occ = occ_state(int'(count_q), DEPTH);

    // Handshake terms depend only on registered occupancy and the controller,
    // never on out_ready/stall, so no combinational ready path crosses the block.
    assign in_ready  = (occ != OCC_FULL) & ~nullify;
    assign out_valid = (occ != OCC_EMPTY) & ~bubble;
    assign enq       = in_valid & in_ready;
    assign deq       = out_valid & out_ready & ~stall & ~nullify;
    assign out_data  = storage_q[rd_ptr];

    always_comb begin
        count_d   = count_q;
        flushed_d = flushed_q;
        if (nullify) begin
            count_d   = '0;
            flushed_d = count_q;
        end else begin
            case ({enq, deq})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q   <= '0;
            flushed_q <= '0;
        end else begin
            count_q   <= count_d;
            flushed_q <= flushed_d;
        end
    end

    // Flushed entries are left in place; only the pointers and count forget them.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++)
                storage_q[i] <= NOP_PAYLOAD;
        end else if (enq) begin
            storage_q[wr_ptr] <= in_data;
        end
    end

    pipeline_ptr_ctr #(.W(PTR_W)) u_rd_ptr (
        .clk   (clk),
        .reset (reset),
        .clr_i (nullify),
        .inc_i (deq),
        .ptr_o (rd_ptr)
    );

    pipeline_ptr_ctr #(.W(PTR_W)) u_wr_ptr (
        .clk   (clk),
        .reset (reset),
        .clr_i (nullify),
        .inc_i (enq),
        .ptr_o (wr_ptr)
    );

    assign count   = count_q;
    assign flushed = flushed_q;

endmodule

// File: doc/pipeline_stage_buffer.md
# pipeline_stage_buffer

- Parametrised successor to the fixed single-register pipeline stage.
- Sits between two pipeline stages and carries an opaque packed payload of WIDTH bits (the stage's `pipeline_signal_t` cast to packed form, or any narrower bundle) through a DEPTH-entry elastic buffer.
- Upstream side uses a valid/ready handshake; downstream side uses valid/ready plus the hazard controller's stall, bubble and nullify.
- New relative to the fixed register: multi-entry decoupling, an explicit handshake, an occupancy report, and a count of entries discarded by flushes.

## Interface
- WIDTH, 32: payload width in bits, ≥1.
- DEPTH, 2: buffer entries; power of two, ≥2.
- CW, $clog2(DEPTH+1): width of occupancy count (derived, not overridden).
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- in_valid  input  1  upstream offers in_data.
- in_data  input  WIDTH  payload from upstream.
- in_ready  output  1  buffer accepts this cycle.
- out_valid  output  1  out_data is a live instruction.
- out_data  output  WIDTH  head entry payload.
- out_ready  input  1  downstream consumes the head this cycle.
- stall  input  1  controller: hold head, no dequeue; enqueue still permitted.
- bubble  input  1  controller: present a NOP downstream (out_valid=0), no dequeue.
- nullify  input  1  controller: flush every entry at the next edge.
- count  output  CW  current occupancy, 0..DEPTH.
- flushed  output  CW  entries discarded by the most recent nullify; held until the next nullify.

## Operation
- Circular storage of DEPTH × WIDTH.
- Read/write pointers are $clog2(DEPTH) bits and wrap modulo DEPTH; count is tracked separately.
- Derived states:
  - EMPTY: count=0.
  - PARTIAL: 0<count<DEPTH.
  - FULL: count=DEPTH.
- in_ready = (count≠DEPTH) & ~nullify. It must not depend on out_ready or stall, so there is no combinational ready path through the block.
- enq = in_valid & in_ready.
- out_valid = (count≠0) & ~bubble.
- deq = out_valid & out_ready & ~stall & ~nullify.
- out_data always shows storage[rd_ptr]. Contents are undefined-but-stable when count=0 (reset value 0).
- Normal update:
  - count_next = count + enq − deq.
  - enq writes in_data at wr_ptr; wr_ptr++.
  - deq advances rd_ptr.
- Simultaneous enq and deq in PARTIAL: count unchanged, both pointers advance.
- FULL: enq is impossible (in_ready=0) even if deq fires the same cycle.
- EMPTY: no bypass; in_data reaches out_data one cycle after enq.
- Priority, highest first:
  1. reset
  2. nullify: count←0, rd_ptr←wr_ptr←0, flushed←count, in_data dropped
  3. bubble / stall (both block deq; bubble additionally masks out_valid)
  4. normal handshake
- stall and bubble together: out_valid=0, no deq.
- nullify while count=0: flushed←0.
- Payload is never inspected or modified.

## Timing
- Reset values: out_valid=0, in_ready=1, count=0, flushed=0, out_data=0, pointers 0, storage 0.
- Reset may assert mid-transfer. Every register clears asynchronously, and in_ready/out_valid take their reset values immediately.
- Latency in→out: 1 cycle when EMPTY; otherwise determined by queue position.
- Throughput: 1 entry/cycle sustained in PARTIAL.
- count and flushed are registered; they reflect the last edge.
- in_ready and out_valid are combinational from registered state plus nullify/bubble only.
- Upstream may drop in_valid without being accepted. The buffer imposes no hold rule on upstream.

## Structure
- Shared package `pipeline_pkg` holds:
  - the packed counterpart of `pipeline_signal_t` (`pipeline_signal_packed_t`);
  - `PIPE_NOP` (all-zero payload) constant.
- One natural sub-module: `pipeline_ptr_ctr`, a wrapping pointer with increment and synchronous clear. It is instantiated twice (rd, wr).
- The controller modport stays as is (drives nullify/stall/bubble). This block replaces the bare register inside a stage.

## Test plan
Parameters: WIDTH=32, DEPTH=4 unless stated.
- Reset then idle: out_valid=0, in_ready=1, count=0, out_data=0. Assert reset mid-stream with count=3: all outputs return to reset values without a clock edge.
- Fill: push 0x11,0x22,0x33,0x44 with out_ready=0. count reaches 4, in_ready=0 on cycle 5. Then out_ready=1: head sequence 0x11..0x44 in order, one per cycle.
- Wrap: 10 back-to-back pushes with out_ready=1. Outputs equal inputs in order with 1-cycle latency, count stays 1, pointers wrap twice.
- Stall vs bubble:
  - count=2 head 0xA, stall=1 for 3 cycles: out_valid=1, head stays 0xA, and two pushes raise count to 4.
  - bubble=1 one cycle: out_valid=0 that cycle, head still 0xA next cycle.
- Nullify at count=3 with in_valid=1 (data 0x55): next cycle count=0, flushed=3, out_valid=0, 0x55 never appears. Second nullify while empty: flushed=0.
- DEPTH=2, WIDTH=8, full with simultaneous out_ready=1 and in_valid=1: one deq, no enq (in_ready=0), count 2→1.
